// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// Optional per-requester grant counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 4,
    parameter int NREQ   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DATA_W-1:0]     req_data,
    input  logic [$clog2(DEPTH):0]     fifo_count,
    output logic [NREQ-1:0]            gnt,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_data
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*8-1:0]          grant_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   r_gnt;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_data;
    logic [PW-1:0]     r_rr_ptr;

    logic [SW-1:0]     w_sum;
    logic              w_space;
    logic              w_found;
    logic              w_grant;
    logic [PW-1:0]     w_winner;
    logic [PW-1:0]     w_next_ptr;
    logic [DATA_W-1:0] w_data;

    // The write in flight lands on this same edge, so count it as occupied.
    assign w_sum   = {1'b0, fifo_count} + SW'(r_wr_en);
    assign w_space = (w_sum < SW'(DEPTH));

    // First pass finds requesters at or above the pointer; second pass wraps to the lowest index.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (i >= int'(r_rr_ptr))) begin
                w_found  = 1'b1;
                w_winner = PW'(i);
                w_data   = req_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i]) begin
                w_found  = 1'b1;
                w_winner = PW'(i);
                w_data   = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_grant    = w_space && w_found;
    assign w_next_ptr = (int'(w_winner) == NREQ - 1) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt    <= '0;
            r_wr_en  <= 1'b0;
            r_data   <= '0;
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_gnt    <= NREQ'(1) << w_winner;
            r_wr_en  <= 1'b1;
            r_data   <= w_data;
            r_rr_ptr <= w_next_ptr;
        end else begin
            r_gnt    <= '0;
            r_wr_en  <= 1'b0;
        end
    end

    assign gnt        = r_gnt;
    assign fifo_wr_en = r_wr_en;
    assign fifo_data  = r_data;

`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*8-1:0] r_grant_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt <= '0;
        end else if (w_grant) begin
            for (int i = 0; i < NREQ; i++) begin
                if ((int'(w_winner) == i) && (r_grant_cnt[i*8 +: 8] != 8'hFF)) begin
                    r_grant_cnt[i*8 +: 8] <= r_grant_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule
